// File: rtl/spi_word_gen.sv
// Transmit-word source for the SPI block: advances master/slave words after each transfer
// (hold / increment / LFSR / debounced button step) and counts completed transfers.
module spi_word_gen #(
  parameter int              WIDTH           = 13,
  parameter logic [WIDTH-1:0] MTX_INIT       = 13'h1dad,
  parameter logic [WIDTH-1:0] STX_INIT       = 13'h0ced,
  parameter logic [WIDTH-1:0] LFSR_POLY      = 13'h100d,
  parameter int              DEBOUNCE_CYCLES = 270000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic             step_btn,
  output logic [WIDTH-1:0] mtx_dat,
  output logic [WIDTH-1:0] stx_dat,
  output logic             adv,
  output logic [15:0]      xfer_count
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_INC  = 2'b01,
    MODE_LFSR = 2'b10,
    MODE_STEP = 2'b11
  } mode_t;

  logic            load_q;
  logic            sync1;
  logic            sync2;
  logic            btn_state;
  logic [DB_W-1:0] db_cnt;
  logic            press;
  logic            done;
  logic            adv_ev;

  assign done   = load_q & ~load;
  assign adv_ev = (mode == MODE_STEP) ? press : done;

  function automatic logic [WIDTH-1:0] next_word(input logic [WIDTH-1:0] w,
                                                 input logic [1:0]       m);
    logic [WIDTH-1:0] r;
    r = w;
    case (m)
      MODE_HOLD: r = w;
      // An all-zero register would lock the LFSR, so reseed with 1
      MODE_LFSR: r = (w == '0) ? WIDTH'(1) : ((w >> 1) ^ (w[0] ? LFSR_POLY : '0));
      default:   r = w + WIDTH'(1);
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      load_q     <= 1'b0;
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      btn_state  <= 1'b1;
      db_cnt     <= '0;
      press      <= 1'b0;
      mtx_dat    <= MTX_INIT;
      stx_dat    <= STX_INIT;
      adv        <= 1'b0;
      xfer_count <= 16'h0000;
    end else begin
      load_q <= load;
      sync1  <= step_btn;
      sync2  <= sync1;
      press  <= 1'b0;
      adv    <= adv_ev;

      if (sync2 == btn_state) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_state <= sync2;
        db_cnt    <= '0;
        press     <= ~sync2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end

      if (adv_ev) begin
        mtx_dat <= next_word(mtx_dat, mode);
        stx_dat <= next_word(stx_dat, mode);
      end

      if (done && (xfer_count != 16'hffff)) begin
        xfer_count <= xfer_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_word_gen.sv
// Randomised bench for spi_word_gen with a cycle-level reference model and literal spot checks.
module tb_spi_word_gen;
  localparam int W = 13;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         step_btn = 1'b1;
  logic [W-1:0] mtx_dat;
  logic [W-1:0] stx_dat;
  logic         adv;
  logic [15:0]  xfer_count;

  always #5 clk = ~clk;

  spi_word_gen #(
    .WIDTH(W), .MTX_INIT(13'h1dad), .STX_INIT(13'h0ced),
    .LFSR_POLY(13'h100d), .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .mode(mode), .step_btn(step_btn),
    .mtx_dat(mtx_dat), .stx_dat(stx_dat), .adv(adv), .xfer_count(xfer_count)
  );

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b1;
  bit sat_load = 1'b0;
  bit noise = 1'b0;
  int adv_pulses = 0;

  // Reference model state
  logic [W-1:0] m_mtx, m_stx;
  logic         m_adv, m_prev;
  logic [15:0]  m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_next(input logic [W-1:0] w, input logic [1:0] md);
    int v;
    v = int'(w);
    if (md == 2'd0) return w;
    if (md == 2'd2) begin
      if (v == 0) return W'(1);
      v = (v / 2) ^ ((v % 2 == 1) ? 'h100d : 0);
      return W'(v);
    end
    return W'((v + 1) % 8192);
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_mtx  <= 13'h1dad;
      m_stx  <= 13'h0ced;
      m_adv  <= 1'b0;
      m_prev <= 1'b0;
      m_cnt  <= 16'h0;
    end else begin
      m_prev <= load;
      m_adv  <= m_prev && !load && mode != 2'd3;
      if (m_prev && !load && mode != 2'd3) begin
        m_mtx <= model_next(m_mtx, mode);
        m_stx <= model_next(m_stx, mode);
      end
      if (sat_load)
        m_cnt <= 16'hfffd;
      else if (m_prev && !load && m_cnt < 16'hffff)
        m_cnt <= m_cnt + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (adv) adv_pulses++;
    if (check_en) begin
      chk("mtx_dat", 32'(mtx_dat), 32'(m_mtx));
      chk("stx_dat", 32'(stx_dat), 32'(m_stx));
      chk("adv", 32'(adv), 32'(m_adv));
    end
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
  end

  task automatic tick();
    @(negedge clk);
    if (noise && $urandom_range(0, 5) == 0) step_btn = ~step_btn;
  endtask

  task automatic xfer(input int hi, input int lo);
    load = 1'b1;
    repeat (hi) tick();
    load = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b1;
  endtask

  int a0;
  logic [W-1:0] w0;

  initial begin
    // Reset values
    do_reset(3);
    chk("rst_mtx", 32'(mtx_dat), 32'h1dad);
    chk("rst_stx", 32'(stx_dat), 32'h0ced);
    chk("rst_cnt", 32'(xfer_count), 32'h0);
    chk("rst_adv", 32'(adv), 32'h0);

    // STEP mode: words move only on a debounced press
    check_en = 1'b0;
    mode = 2'd3;
    repeat (4) @(negedge clk);
    a0 = adv_pulses;
    step_btn = 1'b0;
    repeat (5) @(negedge clk);
    step_btn = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_adv", 32'(adv_pulses - a0), 32'd0);
    chk("glitch_mtx", 32'(mtx_dat), 32'h1dad);
    step_btn = 1'b0;
    repeat (20) @(negedge clk);
    step_btn = 1'b1;
    repeat (30) @(negedge clk);
    chk("press_adv", 32'(adv_pulses - a0), 32'd1);
    chk("press_mtx", 32'(mtx_dat), 32'h1dae);
    chk("press_stx", 32'(stx_dat), 32'h0cee);
    xfer(3, 3);
    chk("step_xfer_mtx", 32'(mtx_dat), 32'h1dae);
    chk("step_xfer_cnt", 32'(xfer_count), 32'd1);
    chk("step_xfer_adv", 32'(adv_pulses - a0), 32'd1);

    // Reset in the middle of a transfer, load still high on release
    mode = 2'd1;
    load = 1'b1;
    repeat (2) @(negedge clk);
    do_reset(2);
    check_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_cnt0", 32'(xfer_count), 32'd0);
    repeat (7) @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("inc_mtx", 32'(mtx_dat), 32'h1dae);
    chk("inc_stx", 32'(stx_dat), 32'h0cee);
    chk("inc_adv", 32'(adv), 32'd1);
    chk("inc_cnt", 32'(xfer_count), 32'd1);
    @(negedge clk);
    chk("inc_adv_off", 32'(adv), 32'd0);

    // LFSR from reset
    do_reset(2);
    mode = 2'd2;
    xfer(2, 2);
    chk("lfsr_mtx", 32'(mtx_dat), 32'h1edb);
    chk("lfsr_stx", 32'(stx_dat), 32'h167b);

    // HOLD: adv pulses but words stay put
    do_reset(2);
    mode = 2'd0;
    a0 = adv_pulses;
    for (int i = 0; i < 5; i++) xfer(1, 1);
    repeat (2) @(negedge clk);
    chk("hold_mtx", 32'(mtx_dat), 32'h1dad);
    chk("hold_stx", 32'(stx_dat), 32'h0ced);
    chk("hold_adv", 32'(adv_pulses - a0), 32'd5);
    chk("hold_cnt", 32'(xfer_count), 32'd5);

    // Random traffic in the non-step modes with button noise (must be ignored)
    noise = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 2));
      xfer($urandom_range(1, 4), $urandom_range(1, 4));
    end
    noise = 1'b0;
    step_btn = 1'b1;

    // INC wrap, then LFSR escape from zero
    do_reset(2);
    mode = 2'd1;
    for (int i = 0; i < 594; i++) xfer(1, 1);
    chk("wrap_pre", 32'(mtx_dat), 32'h1fff);
    xfer(1, 1);
    chk("wrap_zero", 32'(mtx_dat), 32'h0000);
    mode = 2'd2;
    w0 = stx_dat;
    xfer(1, 1);
    chk("lfsr_zero", 32'(mtx_dat), 32'h0001);
    chk("lfsr_stx_changed", 32'(stx_dat != w0), 32'd1);

    // Counter saturation, starting just below the ceiling
    mode = 2'd0;
    repeat (2) @(negedge clk);
    #1;
    force dut.xfer_count = 16'hfffd;
    sat_load = 1'b1;
    @(negedge clk);
    #1;
    release dut.xfer_count;
    sat_load = 1'b0;
    for (int i = 0; i < 5; i++) xfer(1, 1);
    chk("sat_cnt", 32'(xfer_count), 32'hffff);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, limit %0d", 2000000);
    $fatal(1, "timeout");
  end
endmodule
